// File: rtl/hex_ctrl_pkg.sv
// Shared constants, state encoding and leading-zero helper for the hex scan controller.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
package hex_ctrl_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int DATA_W     = 4 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Digit k is blanked when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DATA_W-1:0] data);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    m    = {NUM_DIGITS{1'b0}};
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      seen = seen | (data[4*k +: 4] != 4'h0);
      m[k] = ~seen;
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_seg7.sv
// Hex nibble to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
module seg7 (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Pure lookup; the controller shares one instance across all digits.
  always_comb begin
    o_seg = 7'h7F;
    case (i_nib)
      4'h0:    o_seg = 7'b1000000;
      4'h1:    o_seg = 7'b1111001;
      4'h2:    o_seg = 7'b0100100;
      4'h3:    o_seg = 7'b0110000;
      4'h4:    o_seg = 7'b0011001;
      4'h5:    o_seg = 7'b0010010;
      4'h6:    o_seg = 7'b0000010;
      4'h7:    o_seg = 7'b1111000;
      4'h8:    o_seg = 7'b0000000;
      4'h9:    o_seg = 7'b0010000;
      4'hA:    o_seg = 7'b0001000;
      4'hB:    o_seg = 7'b0000011;
      4'hC:    o_seg = 7'b1000110;
      4'hD:    o_seg = 7'b0100001;
      4'hE:    o_seg = 7'b0000110;
      4'hF:    o_seg = 7'b0001110;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Six-digit hex display controller: captures a load, decodes one digit per cycle through a
// shared seg7, then commits all digits at once. LEADING_ZERO_BLANK_EN adds leading-zero blanking.
module hex_scan_ctrl
  import hex_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic [5:0]        blank_mask,
  output logic              load_ready,
  output logic              done,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_data;
  logic [NUM_DIGITS-1:0] r_mask;
  logic                  r_ready;
  logic                  r_done;
  // The top digit is decoded on the commit edge and goes straight to HEX5, so it needs no shadow.
  logic [6:0]            r_shadow [0:NUM_DIGITS-2];
  logic [6:0]            r_hex    [0:NUM_DIGITS-1];

  logic [IDX_W+1:0]      w_bitpos;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_blank;
  logic [6:0]            w_digit;

  assign w_bitpos = {r_idx, 2'b00};
  assign w_nib    = r_data[w_bitpos +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz = lz_mask(r_data);
`else
  assign w_lz = {NUM_DIGITS{1'b0}};
`endif

  assign w_blank = r_mask[r_idx] | w_lz[r_idx];
  assign w_digit = w_blank ? SEG_BLANK : w_seg;

  seg7 u_seg7 (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // Load capture, digit scan and atomic commit of all six digits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= {IDX_W{1'b0}};
      r_data  <= {DATA_W{1'b0}};
      r_mask  <= {NUM_DIGITS{1'b0}};
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS - 1; k++) r_shadow[k] <= 7'h00;
      for (int k = 0; k < NUM_DIGITS; k++)     r_hex[k]    <= SEG_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load_valid && r_ready) begin
            r_data  <= load_data;
            r_mask  <= blank_mask;
            r_idx   <= {IDX_W{1'b0}};
            r_ready <= 1'b0;
            r_state <= SCAN;
          end else begin
            r_ready <= 1'b1;
          end
        end
        SCAN: begin
          if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
            for (int k = 0; k < NUM_DIGITS - 1; k++) r_hex[k] <= r_shadow[k];
            r_hex[NUM_DIGITS-1] <= w_digit;
            r_idx   <= {IDX_W{1'b0}};
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_shadow[r_idx] <= w_digit;
            r_idx           <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_idx   <= {IDX_W{1'b0}};
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign load_ready = r_ready;
  assign done       = r_done;
  assign HEX0       = r_hex[0];
  assign HEX1       = r_hex[1];
  assign HEX2       = r_hex[2];
  assign HEX3       = r_hex[3];
  assign HEX4       = r_hex[4];
  assign HEX5       = r_hex[5];

endmodule
